// File: rtl/sar_pkg.sv
// Shared definitions for the 8-bit successive-approximation converter.
// State encodings, data width and the first trial mask.
package sar_pkg;

    localparam int W = 8;

    localparam logic [W-1:0] MASK_INIT = 8'h80;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACK    = 3'd1,
        S_TRY    = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Keep the trial bit when the comparator says the input is at or above it.
    function automatic logic [W-1:0] sar_keep(input logic [W-1:0] r,
                                              input logic [W-1:0] mask,
                                              input logic         cmp);
        return cmp ? (r | mask) : r;
    endfunction

endpackage

// File: rtl/sar_avg2.sv
// Average of two 8-bit codes: 9-bit sum, result is sum[8:1] (truncated).
// Used only when SAR_OVERSAMPLE_EN is defined.
module sar_avg2
    import sar_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] avg
);

    assign avg = W'(({1'b0, a} + {1'b0, b}) >> 1);

endmodule

// File: rtl/sar_converter.sv
// SAR converter controller with soc/eoc handshake; drives a DAC code and samples cmp.
// Define SAR_OVERSAMPLE_EN to run two SAR passes and report their average.
module sar_converter
    import sar_pkg::*;
(
    input  logic         clock,
    input  logic         reset_,
    input  logic         soc,
    output logic         eoc,
    output logic [W-1:0] x,
    output logic [W-1:0] dac,
    input  logic         cmp
);

    state_t       state;
    logic [W-1:0] r;
    logic [W-1:0] mask;
    logic [W-1:0] r_dec;
    logic [W-1:0] result;

    assign r_dec = sar_keep(r, mask, cmp);

`ifdef SAR_OVERSAMPLE_EN
    logic         second;
    logic [W-1:0] r1;
    logic [W-1:0] avg;

    sar_avg2 u_avg (
        .a   (r1),
        .b   (r),
        .avg (avg)
    );

    assign result = avg;
`else
    assign result = r;
`endif

    // NOTE: every register here uses <= so all state updates see the pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state <= S_IDLE;
            eoc   <= 1'b1;
            x     <= '0;
            dac   <= '0;
            r     <= '0;
            mask  <= '0;
`ifdef SAR_OVERSAMPLE_EN
            second <= 1'b0;
            r1     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (soc) begin
                        eoc   <= 1'b0;
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!soc) begin
                        r     <= '0;
                        mask  <= MASK_INIT;
                        state <= S_TRY;
`ifdef SAR_OVERSAMPLE_EN
                        second <= 1'b0;
`endif
                    end
                end
                S_TRY: begin
                    dac   <= r | mask;
                    state <= S_DECIDE;
                end
                S_DECIDE: begin
                    r    <= r_dec;
                    mask <= mask >> 1;
                    if (mask == 8'h01) begin
`ifdef SAR_OVERSAMPLE_EN
                        // End of the first pass: park its result and restart the search.
                        if (!second) begin
                            second <= 1'b1;
                            r1     <= r_dec;
                            r      <= '0;
                            mask   <= MASK_INIT;
                            state  <= S_TRY;
                        end else begin
                            state <= S_DONE;
                        end
`else
                        state <= S_DONE;
`endif
                    end else begin
                        state <= S_TRY;
                    end
                end
                S_DONE: begin
                    x     <= result;
                    dac   <= '0;
                    eoc   <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_converter.sv
// Self-checking bench for sar_converter: ideal comparator, behavioural model,
// per-cycle compare process plus literal checks of the documented scenarios.
module tb_sar_converter;

`ifdef SAR_OVERSAMPLE_EN
    localparam int LAT    = 34;
    localparam int PASSES = 2;
`else
    localparam int LAT    = 18;
    localparam int PASSES = 1;
`endif

    logic       clock = 1'b0;
    logic       reset_ = 1'b0;
    logic       soc = 1'b0;
    logic       eoc;
    logic [7:0] x;
    logic [7:0] dac;
    logic       cmp;
    logic [7:0] vin = 8'h00;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [7:0] seen_dac [8];
    logic [7:0] last_x = 8'h00;

    sar_converter dut (
        .clock  (clock),
        .reset_ (reset_),
        .soc    (soc),
        .eoc    (eoc),
        .x      (x),
        .dac    (dac),
        .cmp    (cmp)
    );

    always #5 clock = ~clock;

    // Ideal analog comparator.
    assign cmp = (vin >= dac);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Trial k of an ideal binary search for v: the top k bits of v plus the next bit.
    function automatic logic [7:0] trial(input logic [7:0] v, input int k);
        int vi;
        int kept;
        vi   = int'(v);
        kept = (vi >> (8 - k)) << (8 - k);
        return 8'(kept | (1 << (7 - k)));
    endfunction

    // Behavioural model: phase 0 idle, 1 acknowledged, 2 converting (mn = edges since the ack edge).
    int         mphase = 0;
    int         mn = 0;
    int         m_sum;
    int         m_off;
    logic [7:0] mv [2];
    logic       m_eoc = 1'b1;
    logic [7:0] m_x = 8'h00;
    logic [7:0] m_dac = 8'h00;

    always @(posedge clock) begin
        if (!reset_) begin
            mphase = 0;
            m_eoc  = 1'b1;
            m_x    = 8'h00;
            m_dac  = 8'h00;
        end else begin
            case (mphase)
                0: if (soc) begin m_eoc = 1'b0; mphase = 1; end
                1: if (!soc) begin mn = 1; mphase = 2; end
                default: begin
                    mn++;
                    if (mn == LAT) begin
                        m_sum  = int'(mv[0]) + ((PASSES == 2) ? int'(mv[1]) : int'(mv[0]));
                        m_x    = 8'(m_sum / 2);
                        m_eoc  = 1'b1;
                        m_dac  = 8'h00;
                        mphase = 0;
                    end else if (mn % 2 == 0) begin
                        m_off = mn - 2;
                        mv[m_off / 16] = vin;
                        m_dac = trial(vin, (m_off % 16) / 2);
                    end
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("model eoc", 32'(eoc), 32'(m_eoc));
            check("model x", 32'(x), 32'(m_x));
            check("model dac", 32'(dac), 32'(m_dac));
        end
    end

    // Raise soc, confirm eoc falls, hold soc for 'hold' extra cycles, then release it.
    task automatic start(input int hold);
        @(negedge clock);
        soc = 1'b1;
        @(posedge clock);
        #1;
        check("eoc fall", 32'(eoc), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("ack hold eoc", 32'(eoc), 32'd0);
            check("ack hold dac", 32'(dac), 32'h00);
        end
        @(negedge clock);
        soc = 1'b0;
    endtask

    // Full conversion; v2 drives the comparator on the second pass when oversampling.
    task automatic convert(input logic [7:0] v1, input logic [7:0] v2, input int hold);
        logic [7:0] want;
        vin  = v1;
        want = (PASSES == 2) ? 8'((int'(v1) + int'(v2)) / 2) : v1;
        start(hold);
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clock);
            #1;
            if (i < LAT) begin
                check("busy eoc", 32'(eoc), 32'd0);
                check("busy x hold", 32'(x), 32'(last_x));
            end
            if (i % 2 == 0 && i <= 16) seen_dac[(i - 2) / 2] = dac;
            if (i == 17) vin = v2;
        end
        check("done eoc", 32'(eoc), 32'd1);
        check("done x", 32'(x), 32'(want));
        check("done dac", 32'(dac), 32'h00);
        last_x = want;
    endtask

    task automatic wait_eoc_high(input int budget);
        int n;
        n = 0;
        while (eoc !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (eoc !== 1'b1) check("eoc timeout", 32'(eoc), 32'd1);
    endtask

    logic [7:0] a5_seq [8];
    logic [7:0] v;

    initial begin
        a5_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset eoc", 32'(eoc), 32'd1);
        check("reset x", 32'(x), 32'h00);
        check("reset dac", 32'(dac), 32'h00);
        chk_en = 1'b1;
        @(negedge clock);
        reset_ = 1'b1;

        // Reference conversion with literal DAC sequence
        convert(8'hA5, 8'hA5, 0);
        for (int k = 0; k < 8; k++) check("a5 dac seq", 32'(seen_dac[k]), 32'(a5_seq[k]));
        check("a5 x literal", 32'(x), 32'hA5);

        // Extremes; previous x must hold while busy
        convert(8'h00, 8'h00, 1);
        check("zero x literal", 32'(x), 32'h00);
        convert(8'hFF, 8'hFF, 0);
        check("ff x literal", 32'(x), 32'hFF);

        // soc held 5 cycles after eoc falls
        convert(8'h3C, 8'h3C, 5);

        // Reset during the 5th decide step
        vin = 8'h6B;
        start(0);
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset_ = 1'b0;
        @(posedge clock);
        #1;
        check("abort eoc", 32'(eoc), 32'd1);
        check("abort x", 32'(x), 32'h00);
        check("abort dac", 32'(dac), 32'h00);
        @(negedge clock);
        reset_ = 1'b1;
        last_x = 8'h00;
        convert(8'h5A, 8'h5A, 0);
        check("post abort x", 32'(x), 32'h5A);

        // soc held high across the done edge restarts immediately
        vin = 8'h77;
        start(0);
        for (int i = 1; i <= LAT + 1; i++) begin
            @(posedge clock);
            #1;
            if (i == LAT - 3) soc = 1'b1;
            if (i == LAT) begin
                check("rearm done eoc", 32'(eoc), 32'd1);
                check("rearm done x", 32'(x), 32'h77);
            end
        end
        check("rearm eoc fall", 32'(eoc), 32'd0);
        @(negedge clock);
        soc = 1'b0;
        wait_eoc_high(LAT + 10);
        check("rearm second x", 32'(x), 32'h77);
        last_x = 8'h77;

`ifdef SAR_OVERSAMPLE_EN
        convert(8'h10, 8'h13, 0);
        check("os avg literal", 32'(x), 32'h11);
        convert(8'hFF, 8'hFF, 0);
        check("os ff literal", 32'(x), 32'hFF);
`endif

        // Randomized conversions
        for (int t = 0; t < 20; t++) begin
            v = 8'($urandom_range(0, 255));
            convert(v, 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
